// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one fixed-latency pipelined divider among N requesters.
// A tag pipeline matching the divider latency routes each result back and flags divide-by-zero.
module divider_arbiter #(
  parameter int WIDTH   = 64,
  parameter int N       = 4,
  parameter int LATENCY = 32
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [N-1:0]       req_valid_in,
  output logic [N-1:0]       req_ready_out,
  input  logic [N*WIDTH-1:0] req_dividend_in,
  input  logic [N*WIDTH-1:0] req_divisor_in,
  output logic [WIDTH-1:0]   div_dividend_out,
  output logic [WIDTH-1:0]   div_divisor_out,
  output logic               div_valid_out,
  input  logic [WIDTH-1:0]   div_quotient_in,
  input  logic [WIDTH-1:0]   div_remainder_in,
  input  logic               div_valid_in,
  output logic [N-1:0]       res_valid_out,
  output logic [WIDTH-1:0]   quotient_out,
  output logic [WIDTH-1:0]   remainder_out,
  output logic               error_out,
  output logic               sync_err_out,
  output logic               busy_out
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [IDW-1:0]     ptr_r;
  logic [IDW-1:0]     gid_s;
  logic [IDW-1:0]     idx_s;
  logic               grant_s;
  logic               dz_s;
  logic [LATENCY-1:0] tag_valid_r;
  logic [LATENCY-1:0] tag_dz_r;
  logic [IDW-1:0]     tag_id_r [LATENCY];
  logic               sync_err_r;

  // Round-robin search for the first valid requester starting at ptr_r.
  always_comb begin
    grant_s = 1'b0;
    gid_s   = {IDW{1'b0}};
    idx_s   = {IDW{1'b0}};
    for (int k = 0; k < N; k++) begin
      idx_s = IDW'((int'(ptr_r) + k) % N);
      if (!grant_s && !rst_in && req_valid_in[idx_s]) begin
        grant_s = 1'b1;
        gid_s   = idx_s;
      end else begin
        grant_s = grant_s;
      end
    end
  end

  // Issue the winner's operands to the divider in the grant cycle.
  always_comb begin
    req_ready_out    = {N{1'b0}};
    div_valid_out    = grant_s;
    div_dividend_out = {WIDTH{1'b0}};
    div_divisor_out  = {WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (grant_s && (gid_s == IDW'(i))) begin
        req_ready_out[i] = 1'b1;
        div_dividend_out = req_dividend_in[i*WIDTH +: WIDTH];
        div_divisor_out  = req_divisor_in[i*WIDTH +: WIDTH];
      end else begin
        req_ready_out[i] = 1'b0;
      end
    end
    dz_s = (div_divisor_out == {WIDTH{1'b0}});
  end

  // Control state: pointer, tag valid bits and sticky sync error.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr_r       <= {IDW{1'b0}};
      tag_valid_r <= {LATENCY{1'b0}};
      sync_err_r  <= 1'b0;
    end else begin
      tag_valid_r[0] <= grant_s;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid_r[i] <= tag_valid_r[i-1];
      end
      if (grant_s) begin
        ptr_r <= (gid_s == IDW'(N-1)) ? {IDW{1'b0}} : gid_s + IDW'(1);
      end else begin
        ptr_r <= ptr_r;
      end
      if (div_valid_in != tag_valid_r[LATENCY-1]) begin
        sync_err_r <= 1'b1;
      end else begin
        sync_err_r <= sync_err_r;
      end
    end
  end

  // Tag payload shifts unconditionally; it is only meaningful where the valid bit is set.
  always_ff @(posedge clk_in) begin
    tag_id_r[0] <= gid_s;
    tag_dz_r[0] <= dz_s;
    for (int i = 1; i < LATENCY; i++) begin
      tag_id_r[i] <= tag_id_r[i-1];
      tag_dz_r[i] <= tag_dz_r[i-1];
    end
  end

  // Route the divider output by the tag, never by the divider's own valid.
  always_comb begin
    res_valid_out = {N{1'b0}};
    quotient_out  = {WIDTH{1'b0}};
    remainder_out = {WIDTH{1'b0}};
    error_out     = 1'b0;
    if (tag_valid_r[LATENCY-1]) begin
      quotient_out  = div_quotient_in;
      remainder_out = div_remainder_in;
      error_out     = tag_dz_r[LATENCY-1];
      for (int i = 0; i < N; i++) begin
        res_valid_out[i] = (tag_id_r[LATENCY-1] == IDW'(i));
      end
    end else begin
      error_out = 1'b0;
    end
  end

  assign sync_err_out = sync_err_r;
  assign busy_out     = (|tag_valid_r) | grant_s;

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one fixed-latency, fully pipelined, non-stallable divider among N requesters.
- Each cycle at most one request is granted by round-robin and issued into the divider. The requester ID and a divide-by-zero flag travel alongside it in a tag shift register of matching depth.
- When the divider output emerges, the result is routed back to the originating requester.
- Sits between the per-channel math clients and the shared divider; owns all sequencing and the error flagging that the divider itself does not provide.

Parameters:
- WIDTH, 64, operand/result width; must equal the divider's WIDTH.
- N, 4, number of requesters (2..8).
- LATENCY, 32, divider input-to-output latency in clock cycles (divider valid_in to valid_out).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- req_valid_in  input  N  per-requester request valid.
- req_ready_out  output  N  per-requester accept; one-hot or zero.
- req_dividend_in  input  N*WIDTH  packed dividends; requester i at [i*WIDTH +: WIDTH].
- req_divisor_in  input  N*WIDTH  packed divisors, same packing.
- div_dividend_out  output  WIDTH  to divider dividend_in.
- div_divisor_out  output  WIDTH  to divider divisor_in.
- div_valid_out  output  1  to divider data_valid_in.
- div_quotient_in  input  WIDTH  from divider quotient_out.
- div_remainder_in  input  WIDTH  from divider remainder_out.
- div_valid_in  input  1  from divider data_valid_out.
- res_valid_out  output  N  one-hot result strobe to requester i.
- quotient_out  output  WIDTH  shared result bus.
- remainder_out  output  WIDTH  shared result bus.
- error_out  output  1  result is a divide-by-zero; qualified by res_valid_out.
- sync_err_out  output  1  sticky: divider valid disagreed with the tag pipeline.
- busy_out  output  1  any operation in flight or being issued.

Behaviour:
- Reset: all tag stages invalid, round-robin pointer = 0, sync_err_out = 0. All outputs read 0 during and after reset until traffic arrives.
- Arbitration (combinational, same cycle):
  - Search for the first asserted req_valid_in starting at index ptr and wrapping modulo N.
  - The winner g gets req_ready_out[g] = 1.
  - The transfer occurs when valid and ready are both high.
  - No grant while rst_in = 1.
- Pointer: after a grant to g, ptr <= (g+1) mod N; unchanged when there is no grant. Every continuously asserted requester is granted within N cycles.
- Issue (same cycle as grant, combinational):
  - div_valid_out = 1.
  - div_dividend_out / div_divisor_out = requester g's operands.
  - With no grant: div_valid_out = 0 and the operand outputs are 0.
- Requester obligations:
  - Operands must be held stable while valid && !ready.
  - A requester may drop valid without penalty.
- Tag pipeline:
  - LATENCY stages of {valid, id[$clog2(N)-1:0], dz}.
  - Stage 0 loads {grant, g, divisor==0} each cycle; the remaining stages shift every cycle unconditionally, with no stall path.
- Result routing:
  - When the tag-pipeline output valid is 1: res_valid_out[id] = 1, quotient_out/remainder_out = div_quotient_in/div_remainder_in, error_out = dz.
  - All combinational from the pipeline output and the divider inputs, so results reach the requester in the cycle the divider presents them.
  - Total request-to-result latency = LATENCY cycles after the accept cycle.
  - With no valid tag: res_valid_out = 0, error_out = 0, buses 0.
- Divide-by-zero:
  - The request is still issued, which preserves ordering and throughput.
  - Data is passed through unmodified; the divider yields quotient = all ones, remainder = dividend.
  - error_out flags it.
- Sync check: if div_valid_in != tag output valid in any cycle, sync_err_out <= 1 and stays 1 until reset. Results are still routed according to the tag.
- busy_out = (any tag stage valid) | (any req_ready_out).
- Throughput: one issue per cycle across all requesters; at most LATENCY operations in flight; no per-requester limit.
- Reset mid-operation:
  - All in-flight tags are discarded.
  - Divider outputs still draining after reset are ignored: tags are invalid, so nothing is routed.
  - The resulting div_valid_in/tag mismatch sets sync_err_out only if it occurs after rst_in deasserts.
  - Benches must therefore hold rst_in for at least LATENCY cycles, or reset the divider concurrently.

Test Plan:
- Single request, requester 2, 100/7 → req_ready_out = 0b0100 in the same cycle; LATENCY cycles later res_valid_out = 0b0100, quotient 14, remainder 2, error_out 0.
- All 4 requesters assert continuously for 8 cycles with operands (10i+9)/(i+2) → grants in order 0,1,2,3,0,1,2,3; results return in the same order with correct values; one result per cycle for 8 cycles.
- Requester 1 divides 55 by 0 → error_out = 1 with res_valid_out = 0b0010, quotient = all ones, remainder 55; a following 55/5 from requester 1 returns 11 r 0 with error_out = 0.
- Back-to-back max operands, requester 3: (2^64−1)/1 then (2^64−1)/(2^64−1) → q = 2^64−1 r 0, then q = 1 r 0, on consecutive cycles.
- Model a divider whose data_valid_out is forced to 1 for one idle cycle → sync_err_out rises the next cycle and remains 1; no res_valid_out fires that cycle.
- Assert rst_in for LATENCY cycles with 5 operations in flight → no res_valid_out after reset, ptr restarts at 0 (simultaneous requests 0 and 3 → requester 0 granted), sync_err_out = 0.
